// File: rtl/multu_hilo_if.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_if
// Brief    : Operand/funct/readback bundle between control decode and multu_hilo.
// Revision : 1.0  initial release
// ============================================================================
interface multu_hilo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] Output;
    logic             busy;

    modport master (
        output dataA,
        output dataB,
        output Signal,
        input  Output,
        input  busy
    );

    modport slave (
        input  dataA,
        input  dataB,
        input  Signal,
        output Output,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/multu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo
// Brief    : Sequential 32-step shift-add multiplier writing a 2*WIDTH product
//            into the shared Hi/Lo pair; MFHI/MFLO read it back on Output.
//            Optional macro MULT_SIGNED_EN adds the signed MULT funct code.
// Revision : 1.0  initial release
// ============================================================================
module multu_hilo #(
    parameter int WIDTH   = 32,
    parameter int F_MULTU = 25,
    parameter int F_MULT  = 24,
    parameter int F_MFHI  = 16,
    parameter int F_MFLO  = 18
) (
    input  wire logic    clk,
    input  wire logic    reset,
    multu_hilo_if.slave  bus
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [5:0]     c_f_multu = 6'(F_MULTU);
    localparam logic [5:0]     c_f_mfhi  = 6'(F_MFHI);
    localparam logic [5:0]     c_f_mflo  = 6'(F_MFLO);
    localparam logic [CW-1:0]  c_last    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_mcand;
    logic [2*WIDTH-1:0]  r_prod;
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic                w_start;
    logic [WIDTH-1:0]    w_a_load;
    logic [WIDTH-1:0]    w_b_load;
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_prod_shift;
    logic [2*WIDTH-1:0]  w_res;

`ifdef MULT_SIGNED_EN
    localparam logic [5:0] c_f_mult = 6'(F_MULT);

    logic r_neg;
    logic w_signed;

    // Magnitudes in two's complement: the most negative value maps onto itself,
    // which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        w_signed = (bus.Signal == c_f_mult);
        w_start  = (bus.Signal == c_f_multu) || w_signed;
        w_a_load = (w_signed && bus.dataA[WIDTH-1]) ? (~bus.dataA + 1'b1) : bus.dataA;
        w_b_load = (w_signed && bus.dataB[WIDTH-1]) ? (~bus.dataB + 1'b1) : bus.dataB;
        w_res    = r_neg ? (~r_prod + 1'b1) : r_prod;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if (r_state == S_IDLE && w_start) begin
            r_neg <= w_signed && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
        end
    end
`else
    always_comb begin
        w_start  = (bus.Signal == c_f_multu);
        w_a_load = bus.dataA;
        w_b_load = bus.dataB;
        w_res    = r_prod;
    end
`endif

    // One shift-add step: conditional add into the upper half with carry kept,
    // then {carry, prod} shifted right by one.
    always_comb begin
        w_sum        = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_shift = {w_sum, r_prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_count == c_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mcand <= w_a_load;
                        r_prod  <= {{WIDTH{1'b0}}, w_b_load};
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_prod  <= w_prod_shift;
                    r_count <= r_count + 1'b1;
                end
                S_DONE: begin
                    r_hi <= w_res[2*WIDTH-1:WIDTH];
                    r_lo <= w_res[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // Readback only ever exposes committed Hi/Lo, never the partial product.
    always_comb begin
        bus.Output = '0;
        if (bus.Signal == c_f_mfhi) begin
            bus.Output = r_hi;
        end else if (bus.Signal == c_f_mflo) begin
            bus.Output = r_lo;
        end
    end

    assign bus.busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_multu_hilo
// Brief    : Scoreboard bench for multu_hilo: products queued at start,
//            compared through MFHI/MFLO once the run completes.
// Revision : 1.0  initial release
// ============================================================================
module tb_multu_hilo;

    localparam logic [5:0] c_f_multu = 6'd25;
    localparam logic [5:0] c_f_mult  = 6'd24;
    localparam logic [5:0] c_f_mfhi  = 6'd16;
    localparam logic [5:0] c_f_mflo  = 6'd18;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] sb[$];

    multu_hilo_if #(.WIDTH(32)) bus ();

    multu_hilo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [5:0] code, output logic [31:0] v);
        bus.Signal = code;
        #1;
        v = bus.Output;
    endtask

    // Start edge is the posedge following this call; expected result queued here.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] code, input bit hold, input bit push);
        logic [63:0] e;
        @(negedge clk);
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = code;
        if (code == c_f_mult) e = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        else                  e = {32'd0, a} * {32'd0, b};
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.Signal = 6'd0;
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!bus.busy) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic pop_cmp(input string tag);
        logic [31:0] hi, lo;
        logic [63:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            rd(c_f_mfhi, hi);
            rd(c_f_mflo, lo);
            bus.Signal = 6'd0;
            chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
            chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
        end
    endtask

    task automatic drain(input string tag);
        wait_idle(tag);
        pop_cmp(tag);
    endtask

    initial begin
        logic [31:0] v;
        int          cnt;
        bit          low;

        reset      = 1'b1;
        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.Signal = 6'd0;
        #12;
        rd(c_f_mfhi, v); chk("rst_hi", {32'd0, v}, 64'd0);
        rd(c_f_mflo, v); chk("rst_lo", {32'd0, v}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        reset      = 1'b0;
        bus.Signal = 6'd0;

        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, c_f_multu, 1'b0, 1'b1);
        drain("max");
        start(32'h8000_0000, 32'd2, c_f_multu, 1'b0, 1'b1);
        drain("msb");

        // busy must be high for exactly 33 sampled cycles
        start(32'd3, 32'd5, c_f_multu, 1'b0, 1'b1);
        cnt = 0;
        low = 1'b0;
        for (int i = 0; i < 100 && !low; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
            else          low = 1'b1;
        end
        chk("busy_cycles", 64'(cnt), 64'd33);
        pop_cmp("3x5");

        // Mid-run read sees prior Lo; a second start at T10 is ignored
        start(32'd7, 32'd6, c_f_multu, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rd(c_f_mflo, v); chk("t5_prior_lo", {32'd0, v}, 64'd15);
        bus.Signal = 6'd0;
        repeat (4) @(posedge clk);
        #1;
        bus.dataA  = 32'd100;
        bus.dataB  = 32'd100;
        bus.Signal = c_f_multu;
        @(posedge clk);
        #1;
        bus.Signal = 6'd0;
        chk("t10_busy", {63'd0, bus.busy}, 64'd1);
        drain("7x6");

        // Held start code restarts right after DONE
        start(32'd2, 32'd3, c_f_multu, 1'b1, 1'b1);
        wait_idle("hold1");
        @(posedge clk);
        #1;
        chk("hold_restart", {63'd0, bus.busy}, 64'd1);
        bus.Signal = 6'd0;
        sb.push_back(64'd6);
        pop_cmp("hold_first");
        drain("hold_second");

        // Reset mid-run aborts and clears Hi/Lo immediately
        start(32'd9, 32'd9, c_f_multu, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        rd(c_f_mfhi, v); chk("abort_hi", {32'd0, v}, 64'd0);
        rd(c_f_mflo, v); chk("abort_lo", {32'd0, v}, 64'd0);
        bus.Signal = 6'd0;
        @(negedge clk);
        reset = 1'b0;
        start(32'd2, 32'd4, c_f_multu, 1'b0, 1'b1);
        drain("2x4");

`ifdef MULT_SIGNED_EN
        start(32'hFFFF_FFFE, 32'd3, c_f_mult, 1'b0, 1'b1);
        drain("s_neg2x3");
        start(32'h8000_0000, 32'hFFFF_FFFF, c_f_mult, 1'b0, 1'b1);
        drain("s_minxm1");
`else
        @(negedge clk);
        bus.dataA  = 32'd5;
        bus.dataB  = 32'd7;
        bus.Signal = c_f_mult;
        repeat (3) @(posedge clk);
        #1;
        chk("f24_busy", {63'd0, bus.busy}, 64'd0);
        chk("f24_out", {32'd0, bus.Output}, 64'd0);
        rd(c_f_mflo, v); chk("f24_lo_kept", {32'd0, v}, 64'd8);
        bus.Signal = 6'd0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
